// File: rtl/cache_writeback_buffer.sv
// Coalescing write-back FIFO behind the LRU cache: captures dirty evictions, drains them to
// memory over valid/ready, and lets the cache refill a miss from a still-pending eviction.
module cache_writeback_buffer #(
  parameter int TAG_WIDTH   = 8,
  parameter int VALUE_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [TAG_WIDTH-1:0]       push_tag,
  input  logic [VALUE_WIDTH-1:0]     push_value,
  input  logic [TAG_WIDTH-1:0]       lookup_tag,
  output logic                       lookup_hit,
  output logic [VALUE_WIDTH-1:0]     lookup_value,
  output logic                       mem_req,
  input  logic                       mem_ready,
  output logic [TAG_WIDTH-1:0]       mem_tag,
  output logic [VALUE_WIDTH-1:0]     mem_value,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [TAG_WIDTH-1:0]   tag_q   [DEPTH];
  logic [TAG_WIDTH-1:0]   tag_d   [DEPTH];
  logic [VALUE_WIDTH-1:0] value_q [DEPTH];
  logic [VALUE_WIDTH-1:0] value_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [TAG_WIDTH-1:0]   mem_tag_q, mem_tag_d;
  logic [VALUE_WIDTH-1:0] mem_value_q, mem_value_d;
  logic                   overflow_q, overflow_d;

  logic                   pop, coal_hit, do_coal, do_app, do_drop;
  logic [PTR_W-1:0]       coal_idx;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  function automatic logic [PTR_W-1:0] age_idx(input logic [PTR_W-1:0] base, input int unsigned off);
    return base + PTR_W'(off);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign mem_req  = (state_q == REQ);
  assign mem_tag  = mem_tag_q;
  assign mem_value = mem_value_q;
  assign overflow = overflow_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    pop      = (state_q == REQ) && mem_ready;
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // The presented head is frozen; a same-tag push must append behind it.
      if (valid_q[i] && tag_q[i] == push_tag &&
          !(state_q == REQ && PTR_W'(i) == head_q)) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
    do_coal = push && coal_hit;
    do_app  = push && !coal_hit && (!full || pop);
    do_drop = push && !coal_hit && full && !pop;

    valid_d = valid_q;
    tag_d   = tag_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (do_coal) value_d[coal_idx] = push_value;
    // Applied after the pop so a full-buffer append into the freed slot stays valid.
    if (do_app) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = push_tag;
      value_d[tail_q] = push_value;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d    = count_q + CNT_W'(do_app) - CNT_W'(pop);
    overflow_d = overflow_q | do_drop;

    // The head is loaded from the next-state arrays so a same-cycle push is forwarded.
    state_d     = state_q;
    mem_tag_d   = mem_tag_q;
    mem_value_d = mem_value_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = REQ;
          mem_tag_d   = tag_d[head_q];
          mem_value_d = value_d[head_q];
        end
      end
      REQ: begin
        if (pop) begin
          if (count_d != '0) begin
            mem_tag_d   = tag_d[head_d];
            mem_value_d = value_d[head_d];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Youngest match wins: later ages overwrite earlier ones.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_value = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[age_idx(head_q, k)] && tag_q[age_idx(head_q, k)] == lookup_tag) begin
        lookup_hit   = 1'b1;
        lookup_value = value_q[age_idx(head_q, k)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_tag_q   <= '0;
      mem_value_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_tag_q   <= mem_tag_d;
      mem_value_q <= mem_value_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the payload arrays are not reset; every read is qualified by a valid bit.
  always_ff @(posedge clk) begin
    tag_q   <= tag_d;
    value_q <= value_d;
  end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed bench for cache_writeback_buffer: a vector table for fill/overflow/drain plus
// hand-written sequences for coalescing, head exception, full-with-transfer and async reset.
module tb_cache_writeback_buffer;

  logic        clk;
  logic        rst;
  logic        push;
  logic [7:0]  push_tag;
  logic [31:0] push_value;
  logic [7:0]  lookup_tag;
  logic        lookup_hit;
  logic [31:0] lookup_value;
  logic        mem_req;
  logic        mem_ready;
  logic [7:0]  mem_tag;
  logic [31:0] mem_value;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cache_writeback_buffer #(.TAG_WIDTH(8), .VALUE_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .push(push), .push_tag(push_tag), .push_value(push_value),
    .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_value(lookup_value),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_tag(mem_tag), .mem_value(mem_value),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [7:0]  ptag;
    logic [31:0] pval;
    logic        ready;
    logic [7:0]  ltag;
    logic        e_req;
    logic        chk_mem;
    logic [7:0]  e_mtag;
    logic [31:0] e_mval;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic        e_hit;
    logic [31:0] e_lval;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic p, input logic [7:0] pt, input logic [31:0] pv,
                              input logic r, input logic [7:0] lt, input logic req,
                              input logic cm, input logic [7:0] mt, input logic [31:0] mv,
                              input logic [2:0] c, input logic f, input logic e,
                              input logic o, input logic h, input logic [31:0] lv);
    vec_t v;
    v.push = p; v.ptag = pt; v.pval = pv; v.ready = r; v.ltag = lt;
    v.e_req = req; v.chk_mem = cm; v.e_mtag = mt; v.e_mval = mv; v.e_cnt = c;
    v.e_full = f; v.e_empty = e; v.e_ovf = o; v.e_hit = h; v.e_lval = lv;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [7:0] t, input logic [31:0] v,
                       input logic r, input logic [7:0] lt);
    push = p; push_tag = t; push_value = v; mem_ready = r; lookup_tag = lt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    rst = 1'b0;
    #7;
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [79:0] obs, exp;
    logic [7:0]  rtags [3];

    rst = 1'b1;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    #2;
    do_reset();

    // Reset state
    check("reset_state", {mem_req, mem_tag, mem_value, overflow, empty, full, count},
          {1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0});

    // Fill, overflow, drain
    //             push ptag   pval        rdy   ltag   req  cm   mtag   mval        cnt   f     e     o     h     lval
    vecs[0] = mk(1'b1, 8'h01, 32'hA1, 1'b0, 8'h01, 1'b0, 1'b1, 8'h00, 32'h0,  3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1);
    vecs[1] = mk(1'b1, 8'h02, 32'hA2, 1'b0, 8'h02, 1'b1, 1'b1, 8'h01, 32'hA1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA2);
    vecs[2] = mk(1'b1, 8'h03, 32'hA3, 1'b0, 8'h03, 1'b1, 1'b1, 8'h01, 32'hA1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA3);
    vecs[3] = mk(1'b1, 8'h04, 32'hA4, 1'b0, 8'h04, 1'b1, 1'b1, 8'h01, 32'hA1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA4);
    vecs[4] = mk(1'b1, 8'h05, 32'hA5, 1'b0, 8'h05, 1'b1, 1'b1, 8'h01, 32'hA1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[5] = mk(1'b0, 8'h00, 32'h0,  1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 32'hA2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[6] = mk(1'b0, 8'h00, 32'h0,  1'b1, 8'h02, 1'b1, 1'b1, 8'h03, 32'hA3, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[7] = mk(1'b0, 8'h00, 32'h0,  1'b1, 8'h03, 1'b1, 1'b1, 8'h04, 32'hA4, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[8] = mk(1'b0, 8'h00, 32'h0,  1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0,  3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].push, vecs[i].ptag, vecs[i].pval, vecs[i].ready, vecs[i].ltag);
      tick();
      obs = {mem_req, (vecs[i].chk_mem ? mem_tag : 8'h00), (vecs[i].chk_mem ? mem_value : 32'h0),
             count, full, empty, overflow, lookup_hit, lookup_value};
      exp = {vecs[i].e_req, vecs[i].e_mtag, vecs[i].e_mval, vecs[i].e_cnt, vecs[i].e_full,
             vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_hit, vecs[i].e_lval};
      check($sformatf("vec%0d", i), {48'h0, obs}, {48'h0, exp});
    end

    // Single push, present, one transfer
    do_reset();
    drive(1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 8'h00);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    tick();
    check("single_present", {mem_req, mem_tag, mem_value, count},
          {1'b1, 8'h12, 32'hDEADBEEF, 3'd1});
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    check("single_done", {mem_req, empty, count}, {1'b0, 1'b1, 3'd0});

    // Coalescing a non-head entry
    do_reset();
    drive(1'b1, 8'h10, 32'h1, 1'b0, 8'h20);
    tick();
    drive(1'b1, 8'h20, 32'h2, 1'b0, 8'h20);
    tick();
    drive(1'b1, 8'h20, 32'h3, 1'b0, 8'h20);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h20);
    check("coal_count", {count, lookup_hit, lookup_value}, {3'd2, 1'b1, 32'h3});
    check("coal_head", {mem_req, mem_tag, mem_value}, {1'b1, 8'h10, 32'h1});
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h20);
    tick();
    check("coal_second", {mem_req, mem_tag, mem_value, count}, {1'b1, 8'h20, 32'h3, 3'd1});
    tick();
    check("coal_drained", {mem_req, empty}, {1'b0, 1'b1});

    // Same-tag push against the presented head appends
    do_reset();
    drive(1'b1, 8'h10, 32'h1, 1'b0, 8'h10);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h10);
    tick();
    drive(1'b1, 8'h10, 32'h9, 1'b0, 8'h10);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h10);
    check("head_exc", {mem_req, mem_value, count, lookup_hit, lookup_value},
          {1'b1, 32'h1, 3'd2, 1'b1, 32'h9});
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h10);
    tick();
    check("head_exc_second", {mem_req, mem_tag, mem_value, count}, {1'b1, 8'h10, 32'h9, 3'd1});
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h10);
    check("head_exc_drained", {empty, lookup_hit}, {1'b1, 1'b0});

    // Push while full in the same cycle as a transfer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h41 + 8'(i), 32'h141 + 32'(i), 1'b0, 8'h00);
      tick();
    end
    check("full_before", {full, count, mem_tag}, {1'b1, 3'd4, 8'h41});
    drive(1'b1, 8'h30, 32'h30, 1'b1, 8'h30);
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h30);
    check("full_xfer", {count, full, overflow, mem_tag, lookup_hit, lookup_value},
          {3'd4, 1'b1, 1'b0, 8'h42, 1'b1, 32'h30});
    tick();
    check("full_drain1", {mem_tag, mem_value}, {8'h43, 32'h143});
    tick();
    check("full_drain2", {mem_tag, mem_value}, {8'h44, 32'h144});
    tick();
    check("full_drain3", {mem_req, mem_tag, mem_value, count}, {1'b1, 8'h30, 32'h30, 3'd1});
    tick();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
    check("full_drained", {mem_req, empty, overflow}, {1'b0, 1'b1, 1'b0});

    // Asynchronous reset mid-request
    do_reset();
    rtags[0] = 8'h61; rtags[1] = 8'h62; rtags[2] = 8'h63;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rtags[i], 32'h600 + 32'(i), 1'b0, 8'h00);
      tick();
    end
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h00);
    check("pre_async", {mem_req, count}, {1'b1, 3'd3});
    #1;
    rst = 1'b0;
    #1;
    check("async_clear", {mem_req, count, empty, mem_tag, mem_value},
          {1'b0, 3'd0, 1'b1, 8'h00, 32'h0});
    for (int i = 0; i < 3; i++) begin
      lookup_tag = rtags[i];
      #1;
      check($sformatf("async_lookup%0d", i), {lookup_hit, lookup_value}, {1'b0, 32'h0});
    end
    rst = 1'b1;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h61);
    tick();
    tick();
    check("after_async", {mem_req, count, lookup_hit}, {1'b0, 3'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
